// File: rtl/ccr_flag_unit_pkg.sv
// Shared constants for the condition-code register: flag layout,
// jump condition encodings and the reset flag value.
package ccr_flag_unit_pkg;

  localparam int FLAG_W = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    COND_JZ  = 2'b00,
    COND_JN  = 2'b01,
    COND_JC  = 2'b10,
    COND_JMP = 2'b11
  } cond_e;

  localparam logic [FLAG_W-1:0] FLAGS_RST = '0;

endpackage

// File: rtl/ccr_flag_stack.sv
// Saturating LIFO of flag snapshots for nested interrupts.
// Pop wins over push; overflow/underflow set a sticky error.
module ccr_flag_stack
  import ccr_flag_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] dataIn,
  output logic [FLAG_W-1:0] dataOut,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [FLAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [AW-1:0]     top;

  assign top     = ptr[AW-1:0] - AW'(1);
  assign dataOut = mem[top];
  assign full    = (ptr == PW'(DEPTH));
  assign empty   = (ptr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      err <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       ptr <= ptr - PW'(1);
    end else if (push) begin
      if (full) begin
        err <= 1'b1;
      end else begin
        mem[ptr[AW-1:0]] <= dataIn;
        ptr <= ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ccr_flag_unit.sv
// Execute-stage condition-code register with branch evaluation.
// Define CCR_FLAG_FORWARD_EN to let jumps see same-cycle ALU flags.
module ccr_flag_unit
  import ccr_flag_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aluCarry,
  input  logic              aluSign,
  input  logic              aluZero,
  input  logic              flagWrite,
  input  logic              setCarry,
  input  logic              clrCarry,
  input  logic              jmpReq,
  input  logic [1:0]        jmpCond,
  input  logic              intSave,
  input  logic              intRestore,
  input  logic              stall,
  output logic [FLAG_W-1:0] flags,
  output logic              takeBranch,
  output logic              stackFull,
  output logic              stackEmpty,
  output logic              stackErr
);

  logic [FLAG_W-1:0] wr_flags;
  logic [FLAG_W-1:0] eval_flags;
  logic [FLAG_W-1:0] nxt_flags;
  logic [FLAG_W-1:0] top_flags;
  logic              hit;
  logic              push;
  logic              pop;

  always_comb begin
    wr_flags = flags;
    if (flagWrite) wr_flags = {aluCarry, aluSign, aluZero};
    if (setCarry)      wr_flags[FLAG_C] = 1'b1;
    else if (clrCarry) wr_flags[FLAG_C] = 1'b0;
  end

`ifdef CCR_FLAG_FORWARD_EN
  assign eval_flags = (flagWrite & ~intRestore) ? wr_flags : flags;
`else
  assign eval_flags = flags;
`endif

  always_comb begin
    hit = 1'b0;
    unique case (cond_e'(jmpCond))
      COND_JZ:  hit = eval_flags[FLAG_Z];
      COND_JN:  hit = eval_flags[FLAG_N];
      COND_JC:  hit = eval_flags[FLAG_C];
      COND_JMP: hit = 1'b1;
    endcase
  end

  assign takeBranch = jmpReq & hit;

  // A taken conditional jump consumes the flag it tested.
  always_comb begin
    nxt_flags = wr_flags;
    if (takeBranch) begin
      unique case (cond_e'(jmpCond))
        COND_JZ:  nxt_flags[FLAG_Z] = 1'b0;
        COND_JN:  nxt_flags[FLAG_N] = 1'b0;
        COND_JC:  nxt_flags[FLAG_C] = 1'b0;
        COND_JMP: ;
      endcase
    end
  end

  assign pop  = intRestore & ~stall;
  assign push = intSave & ~intRestore & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= FLAGS_RST;
    end else if (!stall) begin
      if (intRestore) begin
        if (!stackEmpty) flags <= top_flags;
      end else begin
        flags <= nxt_flags;
      end
    end
  end

  ccr_flag_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .dataIn (flags),
    .dataOut(top_flags),
    .full   (stackFull),
    .empty  (stackEmpty),
    .err    (stackErr)
  );

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Scoreboard bench for ccr_flag_unit: directed plan plus random traffic,
// expected values come from a queue-based behavioural model.
module tb_ccr_flag_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       aluCarry = 1'b0, aluSign = 1'b0, aluZero = 1'b0;
  logic       flagWrite = 1'b0, setCarry = 1'b0, clrCarry = 1'b0;
  logic       jmpReq = 1'b0;
  logic [1:0] jmpCond = 2'b00;
  logic       intSave = 1'b0, intRestore = 1'b0, stall = 1'b0;
  logic [2:0] flags;
  logic       takeBranch, stackFull, stackEmpty, stackErr;

  ccr_flag_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .aluCarry(aluCarry), .aluSign(aluSign), .aluZero(aluZero),
    .flagWrite(flagWrite), .setCarry(setCarry), .clrCarry(clrCarry),
    .jmpReq(jmpReq), .jmpCond(jmpCond),
    .intSave(intSave), .intRestore(intRestore), .stall(stall),
    .flags(flags), .takeBranch(takeBranch),
    .stackFull(stackFull), .stackEmpty(stackEmpty), .stackErr(stackErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state: flags as {C,N,Z}, LIFO as a queue (back = top)
  bit [2:0] m_flags = 3'b000;
  bit [2:0] m_stack[$];
  bit       m_err = 1'b0;

  bit       br_q[$];
  bit [5:0] st_q[$];

  task automatic drive(input bit r, input bit fw, input bit [2:0] alu,
                       input bit sc, input bit cc, input bit jr,
                       input bit [1:0] jc, input bit sv, input bit ir,
                       input bit st);
    bit [2:0] ef;
    bit [2:0] nf;
    bit       hit;
    @(negedge clk);
    rst = r; flagWrite = fw;
    {aluCarry, aluSign, aluZero} = alu;
    setCarry = sc; clrCarry = cc; jmpReq = jr; jmpCond = jc;
    intSave = sv; intRestore = ir; stall = st;
    #1;
    // flags after ALU write and SETC/CLRC, before any consumed clear
    nf = fw ? alu : m_flags;
    if (sc) nf[2] = 1'b1;
    else if (cc) nf[2] = 1'b0;
    ef = m_flags;
`ifdef CCR_FLAG_FORWARD_EN
    if (fw && !ir) ef = nf;
`endif
    case (jc)
      2'd0: hit = ef[0];
      2'd1: hit = ef[1];
      2'd2: hit = ef[2];
      default: hit = 1'b1;
    endcase
    hit = hit && jr;
    br_q.push_back(hit);
    if (r) begin
      m_flags = 3'b000;
      m_stack.delete();
      m_err = 1'b0;
    end else if (!st) begin
      if (ir) begin
        if (m_stack.size() > 0) m_flags = m_stack.pop_back();
        else m_err = 1'b1;
      end else begin
        if (sv) begin
          if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
          else m_err = 1'b1;
        end
        if (hit && jc != 2'd3) nf[jc] = 1'b0;
        m_flags = nf;
      end
    end
    st_q.push_back({m_flags, m_stack.size() == DEPTH,
                    m_stack.size() == 0, m_err});
  endtask

  task automatic idle();
    drive(0, 0, 3'b000, 0, 0, 0, 2'd0, 0, 0, 0);
  endtask

  // branch monitor: combinational output checked mid low phase
  initial forever begin
    @(negedge clk);
    #2;
    if (br_q.size() > 0) begin
      bit e;
      e = br_q.pop_front();
      checks++;
      if (takeBranch !== e) begin
        failures++;
        $display("FAIL takeBranch t=%0t got=%b exp=%b", $time, takeBranch, e);
      end
    end
  end

  // state monitor: registered outputs checked just after the edge
  initial forever begin
    @(posedge clk);
    #1;
    if (st_q.size() > 0) begin
      bit [5:0] e;
      e = st_q.pop_front();
      checks++;
      if ({flags, stackFull, stackEmpty, stackErr} !== e) begin
        failures++;
        $display("FAIL state t=%0t got flags=%b full=%b empty=%b err=%b exp flags=%b full=%b empty=%b err=%b",
                 $time, flags, stackFull, stackEmpty, stackErr,
                 e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    int n;
    drive(1, 0, 3'b000, 0, 0, 0, 2'd0, 0, 0, 0);
    // reset mid-interrupt with flags 111 and two snapshots stacked
    drive(0, 1, 3'b111, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 0, 2'd0, 1, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 0, 2'd0, 1, 0, 0);
    drive(1, 1, 3'b010, 1, 0, 1, 2'd3, 1, 1, 0);
    idle();
    // write 101, then JZ taken consumes Z
    drive(0, 1, 3'b101, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 1, 2'd0, 0, 0, 0);
    idle();
    // SETC+CLRC -> C=1, CLRC -> 0, JC not taken
    drive(1, 0, 3'b000, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 3'b000, 1, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 3'b000, 0, 1, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 1, 2'd2, 0, 0, 0);
    // save with concurrent write, then restore
    drive(0, 1, 3'b011, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 1, 3'b100, 0, 0, 0, 2'd0, 1, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 0, 2'd0, 0, 1, 0);
    idle();
    // overflow then underflow with distinct snapshots
    drive(0, 1, 3'b001, 0, 0, 0, 2'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 1, 3'(i + 2), 0, 0, 0, 2'd0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 0, 3'b000, 0, 0, 0, 2'd0, 0, 1, 0);
    // same-cycle write and JZ (forwarding dependent), stall holds
    drive(1, 0, 3'b000, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 1, 3'b001, 0, 0, 1, 2'd0, 0, 0, 0);
    drive(0, 1, 3'b111, 1, 0, 1, 2'd3, 1, 1, 1);
    drive(0, 1, 3'b110, 0, 0, 0, 2'd0, 0, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 1, 2'd1, 1, 1, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 1), 3'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1), 2'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0);
    end
    idle();
    n = 0;
    while ((br_q.size() > 0 || st_q.size() > 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    #3;
    if (br_q.size() > 0 || st_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending_br=%0d pending_st=%0d exp=0",
               br_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
